booth_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier: 8-bit two's-complement multiplicand × 8-bit two's-complement multiplier → 16-bit two's-complement product. It is the multiplication counterpart of the non-restoring divider. It reuses the same add/subtract-and-shift datapath style: one 9-bit add or subtract plus one arithmetic shift per clock. Driven by a start/done handshake from the surrounding arithmetic controller.

---
 rtl/booth_multiplier.sv | 135 +++++++++++++
 tb/tb_booth_multiplier.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// ---------------------------------------------------------------------------
// booth_multiplier
//   Sequential radix-2 Booth multiplier, 8-bit signed x 8-bit signed -> 16-bit
//   signed. Each COMPUTE cycle does one 9-bit add/subtract followed by one
//   arithmetic right shift of {A,Q,q_1}. Eight iterations, then a one-cycle
//   done pulse.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   request, accepted only while busy=0
//   multiplicand in   8   signed operand M, captured on accepted start
//   multiplier   in   8   signed operand Q, captured on accepted start
//   busy         out  1   high while an operation is in progress (registered)
//   done         out  1   one-cycle pulse, product valid (registered)
//   product      out  16  signed result, held until the next completion
// ---------------------------------------------------------------------------
module booth_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state, state_next;

  // A and Mx carry a ninth bit so that A - Mx with Mx = -128 cannot overflow.
  logic [8:0]  acc;
  logic [8:0]  mx;
  logic [7:0]  q;
  logic        q_1;
  logic [2:0]  cnt;

  logic        load;
  logic [8:0]  sum;
  logic [8:0]  acc_shift;
  logic [7:0]  q_shift;

  // Next-state logic. DONE behaves like IDLE for start acceptance, which is
  // what allows a held start to run back-to-back operations.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt == 3'd7) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = COMPUTE;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M, else pass.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + mx;
      2'b10:   sum = acc + ~mx + 9'd1;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift right of {sum, Q, q_1}; the bit leaving Q becomes q_1.
  assign acc_shift = {sum[8], sum[8:1]};
  assign q_shift   = {sum[0], q[7:1]};

  // State register; busy/done are registered from the next state so they
  // never depend combinationally on inputs and can never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == COMPUTE);
      done  <= (state_next == DONE);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= 9'd0;
      mx      <= 9'd0;
      q       <= 8'd0;
      q_1     <= 1'b0;
      cnt     <= 3'd0;
      product <= 16'h0000;
    end else if (load) begin
      acc <= 9'd0;
      mx  <= {multiplicand[7], multiplicand};
      q   <= multiplier;
      q_1 <= 1'b0;
      cnt <= 3'd0;
    end else if (state == COMPUTE) begin
      acc <= acc_shift;
      q   <= q_shift;
      q_1 <= q[0];
      cnt <= cnt + 3'd1;
      // Eighth iteration: the shifted {A[7:0], Q} is the full product.
      if (cnt == 3'd7) begin
        product <= {acc_shift[7:0], q_shift};
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier
//   Directed self-checking bench for booth_multiplier. Inputs change at the
//   falling edge or 1 ns after the rising edge; outputs are sampled 1 ns after
//   the rising edge. Expected products are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_booth_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          n_assert;
  int          n_fail;
  logic [15:0] prev_product;

  booth_multiplier dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation with a one-cycle start. inject_at (1..7) raises
  // start with operands 2,2 so that it is sampled at that iteration edge;
  // it must be ignored.
  task automatic do_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                       input logic [15:0] exp, input int inject_at);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    step();  // E0
    start = 1'b0;
    chk({tag, " E0 busy"}, {15'd0, busy}, 16'd1);
    chk({tag, " E0 done"}, {15'd0, done}, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      if (k == inject_at) begin
        start        = 1'b1;
        multiplicand = 8'd2;
        multiplier   = 8'd2;
      end
      step();
      start = 1'b0;
      if (k < 8) begin
        n_assert++;
        assert (busy === 1'b1 && done === 1'b0 && product === prev_product) else begin
          n_fail++;
          $error("FAIL %s E%0d busy/done/product observed=%b/%b/0x%h expected=1/0/0x%h",
                 tag, k, busy, done, product, prev_product);
        end
      end
    end
    chk({tag, " E8 done"}, {15'd0, done}, 16'd1);
    chk({tag, " E8 busy"}, {15'd0, busy}, 16'd0);
    chk({tag, " E8 product"}, product, exp);
    prev_product = exp;
    step();  // E9
    chk({tag, " E9 done"}, {15'd0, done}, 16'd0);
    chk({tag, " E9 busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    prev_product = 16'h0000;
    rst_n        = 1'b1;
    start        = 1'b0;
    multiplicand = 8'd0;
    multiplier   = 8'd0;

    // Reset asserted mid-cycle: outputs clear without waiting for a clock.
    #13;
    rst_n = 1'b0;
    #1;
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset done", {15'd0, done}, 16'd0);
    chk("reset product", product, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Idle with start low: nothing happens.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle busy", {15'd0, busy}, 16'd0);
      chk("idle done", {15'd0, done}, 16'd0);
    end

    // Basic and signed directed vectors.
    do_op("7x3",       8'd7,   8'd3,   16'h0015, 0);
    do_op("-5x6",      8'hFB,  8'd6,   16'hFFE2, 0);
    do_op("127x-128",  8'h7F,  8'h80,  16'hC080, 0);
    do_op("-128x-128", 8'h80,  8'h80,  16'h4000, 0);
    do_op("0x5A",      8'h00,  8'h5A,  16'h0000, 0);
    do_op("-1x-1",     8'hFF,  8'hFF,  16'h0001, 0);

    // Start plus operand change at clock 4 of a running op is ignored.
    do_op("9x-7 ign",  8'd9,   8'hF9,  16'hFFC1, 4);

    // Back-to-back: start held high with 3 x -3 -> done every 9th clock.
    @(negedge clk);
    multiplicand = 8'd3;
    multiplier   = 8'hFD;
    start        = 1'b1;
    step();  // E0
    chk("b2b E0 busy", {15'd0, busy}, 16'd1);
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 8; k++) begin
        if (r == 2 && k == 8) start = 1'b0;  // drop before E8 of last run... sampled at E9
        step();
        if (k == 4) chk("b2b mid product held", product, prev_product);
      end
      chk("b2b done", {15'd0, done}, 16'd1);
      chk("b2b busy low at done", {15'd0, busy}, 16'd0);
      chk("b2b product", product, 16'hFFF7);
      prev_product = 16'hFFF7;
      step();  // restart edge (or return to IDLE on last run)
      chk("b2b done deasserts", {15'd0, done}, 16'd0);
      chk("b2b busy", {15'd0, busy}, (r < 2) ? 16'd1 : 16'd0);
      chk("b2b product kept", product, 16'hFFF7);
    end

    // Reset mid-operation aborts with no done and product cleared.
    @(negedge clk);
    multiplicand = 8'd10;
    multiplier   = 8'd10;
    start        = 1'b1;
    step();  // E0
    start = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", {15'd0, busy}, 16'd0);
    chk("abort done", {15'd0, done}, 16'd0);
    chk("abort product", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    prev_product = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post-abort no done", {15'd0, done}, 16'd0);
    end
    do_op("4x5 after reset", 8'd4, 8'd5, 16'h0014, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
